cordic_share_arbiter: RTL and testbench
=======================================

// Module: cordic_share_arbiter
// PURPOSE
//  Time-shares one non-pipelined cordic_block among NUM_CH I/Q requesters.
//  Arbitrates round-robin, drives the chosen sample into the CORDIC and waits its fixed latency.
//  Captures o_angle and returns it with the winning channel index and a 1-cycle valid pulse.
//  Sits between per-channel demod front ends and the shared CORDIC/rotation path.
// PARAMETERS
//  NUM_CH      4  number of requesters, 2..8; CH_W = $clog2(NUM_CH) (local)
//  CORDIC_LAT  3  cycles from CORDIC I/Q inputs stable to angle valid, >=1
// PORTS
//  clock         in   1          clock, rising edge
//  reset         in   1          synchronous, active-low reset
//  i_req         in   NUM_CH     per-channel request; hold with data until matching o_gnt
//  i_I           in   NUM_CH*4   packed signed I samples, ch k at [4k+3:4k]
//  i_Q           in   NUM_CH*4   packed signed Q samples, same packing
//  o_gnt         out  NUM_CH     one-hot grant, 1-cycle pulse
//  o_cordic_I    out  4          signed I to shared CORDIC (registered)
//  o_cordic_Q    out  4          signed Q to shared CORDIC (registered)
//  i_cordic_angle in  16         unsigned angle from shared CORDIC
//  o_angle       out  16         captured angle for o_ch
//  o_ch          out  CH_W       channel index of o_angle
//  o_valid       out  1          1-cycle pulse: o_angle/o_ch valid
//  o_busy        out  1          high in every state except IDLE/ARB
// BEHAVIOUR
//  Reset (reset==0 at clock edge): state=IDLE; all outputs 0; rr pointer=NUM_CH-1; counter=0.
//  Reset mid-operation: in-flight sample dropped, no o_valid, no grant; CORDIC shares same reset.
//  FSM:
//   IDLE    1 cycle, -> ARB.
//   ARB     no req: stay. Else pick first set i_req[k] searching ptr+1..ptr+NUM_CH mod NUM_CH;
//           at edge: sel=k, ptr=k, o_cordic_I/Q <= i_I/i_Q slice k; -> ISSUE.
//   ISSUE   o_gnt[sel]=1 (only grant cycle); cnt=CORDIC_LAT-1; -> WAIT, or CAPTURE if LAT==1.
//   WAIT    cnt decrements; at cnt==1 -> CAPTURE.
//   CAPTURE CORDIC_LAT cycles after ISSUE; at edge o_angle<=i_cordic_angle, o_ch<=sel; -> DONE.
//   DONE    o_valid=1; -> ARB.
//  Latency: o_valid asserts CORDIC_LAT+1 cycles after o_gnt; throughput 1 sample/(CORDIC_LAT+3).
//  o_cordic_I/Q held from ISSUE until next ARB grant; o_angle/o_ch held until next CAPTURE.
//  i_req sampled only in ARB; req changes elsewhere are ignored; requester drops req after gnt.
//  Pointer wrap: ptr==NUM_CH-1 -> search starts at ch 0. Single requester re-granted each round.
//  Idle i_cordic_angle ignored outside CAPTURE.
// CONFIGURATION
//  CORDIC_ARB_PRIO_EN defined: channel 0 strict priority; if i_req[0] in ARB it wins,
//   ptr unchanged; other channels round-robin among themselves.
//  Not defined: pure round-robin over all NUM_CH channels, no priority.
// TESTING (NUM_CH=4, CORDIC_LAT=3 unless stated)
//  1 reset, then i_req=4'b0100, ch2 I=3 Q=4'hE -> o_gnt=4'b0100 1 cycle, o_cordic_I/Q=3/E,
//    o_valid 4 cycles after gnt, o_ch=2, o_angle = CORDIC model(3,-2).
//  2 i_req=4'b1111 held -> grants ch 0,1,2,3,0 exactly 6 cycles apart; o_ch follows same order.
//  3 after grant to ch1, i_req=4'b1010 -> next grant ch3, then ch1 (wrap via ptr).
//  4 reset low during WAIT -> no o_valid, all outputs 0 next cycle; then i_req=4'b1111 -> ch0 first.
//  5 i_req=4'b0101 held: with CORDIC_ARB_PRIO_EN -> ch0 every grant; without -> 0,2,0,2.
//  6 CORDIC_LAT=1 -> state skips WAIT; o_valid 2 cycles after gnt, grants 4 cycles apart.

Source files
------------

// File: rtl/cordic_share_arbiter.sv
// cordic_share_arbiter: round-robin time-sharing of one non-pipelined CORDIC among NUM_CH I/Q requesters.
// Define CORDIC_ARB_PRIO_EN to give channel 0 strict priority; the other channels round-robin among themselves.
module cordic_share_arbiter #(
    parameter  int NUM_CH     = 4,
    parameter  int CORDIC_LAT = 3,
    localparam int CH_W       = $clog2(NUM_CH),
    localparam int CNT_W      = $clog2(CORDIC_LAT + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   i_req,
    input  logic [NUM_CH*4-1:0] i_I,
    input  logic [NUM_CH*4-1:0] i_Q,
    output logic [NUM_CH-1:0]   o_gnt,
    output logic [3:0]          o_cordic_I,
    output logic [3:0]          o_cordic_Q,
    input  logic [15:0]         i_cordic_angle,
    output logic [15:0]         o_angle,
    output logic [CH_W-1:0]     o_ch,
    output logic                o_valid,
    output logic                o_busy
);
    typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT, CAPTURE, DONE} state_t;
    state_t            r_state;
    logic [CH_W-1:0]   r_ptr;
    logic [CH_W-1:0]   r_sel;
    logic [CNT_W-1:0]  r_cnt;
    logic [CH_W-1:0]   w_pick;
    logic [CH_W-1:0]   w_win;
    logic [NUM_CH-1:0] w_req;
    logic              w_prio;
`ifdef CORDIC_ARB_PRIO_EN
    assign w_prio = i_req[0];
    assign w_req  = {i_req[NUM_CH-1:1], 1'b0};
`else
    assign w_prio = 1'b0;
    assign w_req  = i_req;
`endif
    // Channels above the pointer outrank those at or below it; lowest index wins within each group.
    always_comb begin
        w_pick = '0;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (w_req[k] && CH_W'(k) <= r_ptr) w_pick = CH_W'(k);
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (w_req[k] && CH_W'(k) > r_ptr) w_pick = CH_W'(k);
    end
    assign w_win = w_prio ? '0 : w_pick;
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_ptr      <= CH_W'(NUM_CH - 1);
            r_sel      <= '0;
            r_cnt      <= '0;
            o_gnt      <= '0;
            o_cordic_I <= '0;
            o_cordic_Q <= '0;
            o_angle    <= '0;
            o_ch       <= '0;
            o_valid    <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_gnt   <= '0;
            o_valid <= 1'b0;
            case (r_state)
                IDLE: r_state <= ARB;
                ARB: if (|i_req) begin
                    r_sel      <= w_win;
                    r_ptr      <= w_prio ? r_ptr : w_win;
                    o_cordic_I <= i_I[4*w_win +: 4];
                    o_cordic_Q <= i_Q[4*w_win +: 4];
                    o_gnt      <= NUM_CH'(1) << w_win;
                    o_busy     <= 1'b1;
                    r_state    <= ISSUE;
                end
                ISSUE: begin
                    r_cnt   <= CNT_W'(CORDIC_LAT - 1);
                    r_state <= (CORDIC_LAT == 1) ? CAPTURE : WAIT;
                end
                WAIT: begin
                    r_cnt   <= r_cnt - CNT_W'(1);
                    r_state <= (r_cnt == CNT_W'(1)) ? CAPTURE : WAIT;
                end
                CAPTURE: begin
                    o_angle <= i_cordic_angle;
                    o_ch    <= r_sel;
                    o_valid <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= ARB;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_share_arbiter.sv
// tb_cordic_share_arbiter: directed tests for cordic_share_arbiter with LAT=3 and LAT=1 instances.
// Each instance drives a behavioural fixed-latency atan2 CORDIC.
module tb_cordic_share_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0, req1 = '0;
    logic [15:0] iv = '0, qv = '0;
    logic [3:0]  gnt, gnt1, cI, cQ, cI1, cQ1;
    logic [15:0] ang_in, ang_in1, ang, ang1;
    logic [1:0]  ch, ch1;
    logic        valid, valid1, busy, busy1;
    logic [15:0] pipe3 [3];
    logic [15:0] pipe1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [15:0] cmodel(input logic [3:0] i, input logic [3:0] q);
        real a;
        int  v;
        a = $atan2(real'($signed(q)), real'($signed(i)));
        v = int'(a * 65536.0 / 6.283185307179586);
        return v[15:0];
    endfunction

    always @(posedge clock) begin
        pipe3[0] <= cmodel(cI, cQ);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
        pipe1    <= cmodel(cI1, cQ1);
    end
    assign ang_in  = pipe3[2];
    assign ang_in1 = pipe1;

    cordic_share_arbiter #(.NUM_CH(4), .CORDIC_LAT(3)) u_dut (
        .clock(clock), .reset(reset), .i_req(req), .i_I(iv), .i_Q(qv),
        .o_gnt(gnt), .o_cordic_I(cI), .o_cordic_Q(cQ), .i_cordic_angle(ang_in),
        .o_angle(ang), .o_ch(ch), .o_valid(valid), .o_busy(busy)
    );
    cordic_share_arbiter #(.NUM_CH(4), .CORDIC_LAT(1)) u_dut1 (
        .clock(clock), .reset(reset), .i_req(req1), .i_I(iv), .i_Q(qv),
        .o_gnt(gnt1), .o_cordic_I(cI1), .o_cordic_Q(cQ1), .i_cordic_angle(ang_in1),
        .o_angle(ang1), .o_ch(ch1), .o_valid(valid1), .o_busy(busy1)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_gnt(input bit s, output logic [3:0] g, output int at);
        g  = '0;
        at = -1;
        for (int n = 0; n < 30 && at < 0; n++) begin
            tick();
            if ((s ? gnt1 : gnt) !== 4'b0) begin
                g  = s ? gnt1 : gnt;
                at = cyc;
            end
        end
    endtask

    task automatic wait_valid(input bit s, output int at);
        at = -1;
        for (int n = 0; n < 30 && at < 0; n++) begin
            tick();
            if ((s ? valid1 : valid) === 1'b1) at = cyc;
        end
    endtask

    task automatic test_reset();
        reset_pulse();
        reset = 1'b0;
        tick();
        total++;
        if ({gnt, valid, busy} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctl: gnt/valid/busy=%b want 0", {gnt, valid, busy});
        end
        total++;
        if ({cI, cQ, ang} !== 24'b0) begin
            bad++;
            $display("FAIL reset_data: I/Q/angle=%h want 0", {cI, cQ, ang});
        end
        total++;
        if (ch !== 2'b0) begin
            bad++;
            $display("FAIL reset_ch: got %0d want 0", ch);
        end
        reset = 1'b1;
    endtask

    task automatic test_single();
        logic [3:0] g;
        int tg, tv;
        iv  = 16'h0300;
        qv  = 16'h0E00;
        req = 4'b0100;
        wait_gnt(0, g, tg);
        req = 4'b0000;
        total++;
        if (g !== 4'b0100) begin
            bad++;
            $display("FAIL single_gnt: got %b want 0100", g);
        end
        total++;
        if ({cI, cQ} !== 8'h3E) begin
            bad++;
            $display("FAIL single_iq: got %h want 3e", {cI, cQ});
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL single_busy: got %b want 1", busy);
        end
        tick();
        total++;
        if (gnt !== 4'b0) begin
            bad++;
            $display("FAIL single_gnt_pulse: got %b want 0000", gnt);
        end
        wait_valid(0, tv);
        total++;
        if (tv < 0 || tv - tg != 4) begin
            bad++;
            $display("FAIL single_latency: got %0d want 4", tv - tg);
        end
        total++;
        if (ch !== 2'd2 || ang !== cmodel(4'h3, 4'hE)) begin
            bad++;
            $display("FAIL single_result: ch=%0d angle=%h want ch=2 angle=%h", ch, ang, cmodel(4'h3, 4'hE));
        end
        tick();
        total++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_after: valid=%b busy=%b want 0 0", valid, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] g;
        int tg, tv, prev;
        int k;
        reset_pulse();
        iv   = 16'h4321;
        qv   = 16'hA5F7;
        req  = 4'b1111;
        prev = -1;
        for (int n = 0; n < 5; n++) begin
            k = n % 4;
            wait_gnt(0, g, tg);
            total++;
            if (g !== 4'(1 << k)) begin
                bad++;
                $display("FAIL rr_gnt%0d: got %b want %b", n, g, 4'(1 << k));
            end
            total++;
            if (cI !== iv[4*k +: 4] || cQ !== qv[4*k +: 4]) begin
                bad++;
                $display("FAIL rr_iq%0d: got %h%h want %h%h", n, cI, cQ, iv[4*k +: 4], qv[4*k +: 4]);
            end
            if (n > 0) begin
                total++;
                if (tg - prev != 6) begin
                    bad++;
                    $display("FAIL rr_spacing%0d: got %0d want 6", n, tg - prev);
                end
            end
            prev = tg;
            wait_valid(0, tv);
            total++;
            if (tv < 0 || ch !== 2'(k) || ang !== cmodel(iv[4*k +: 4], qv[4*k +: 4])) begin
                bad++;
                $display("FAIL rr_result%0d: ch=%0d angle=%h want ch=%0d angle=%h", n, ch, ang, k,
                         cmodel(iv[4*k +: 4], qv[4*k +: 4]));
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] g;
        int t;
        wait_gnt(0, g, t);
        req = 4'b1010;
        total++;
        if (g !== 4'b0010) begin
            bad++;
            $display("FAIL wrap_first: got %b want 0010", g);
        end
        wait_gnt(0, g, t);
        total++;
        if (g !== 4'b1000) begin
            bad++;
            $display("FAIL wrap_ch3: got %b want 1000", g);
        end
        wait_gnt(0, g, t);
        req = 4'b0000;
        total++;
        if (g !== 4'b0010) begin
            bad++;
            $display("FAIL wrap_ch1: got %b want 0010", g);
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] g;
        int t;
        req = 4'b1111;
        wait_gnt(0, g, t);
        total++;
        if (g !== 4'b0100) begin
            bad++;
            $display("FAIL midrst_pre: got %b want 0100", g);
        end
        tick();
        reset = 1'b0;
        tick();
        total++;
        if ({gnt, cI, cQ, ang, ch, valid, busy} !== 32'b0) begin
            bad++;
            $display("FAIL midrst_zero: outputs=%h want 0", {gnt, cI, cQ, ang, ch, valid, busy});
        end
        reset = 1'b1;
        wait_gnt(0, g, t);
        req = 4'b0000;
        total++;
        if (g !== 4'b0001) begin
            bad++;
            $display("FAIL midrst_ch0: got %b want 0001", g);
        end
    endtask

    task automatic test_priority();
        logic [3:0] g, e;
        int t;
        reset_pulse();
        req = 4'b0101;
        for (int n = 0; n < 4; n++) begin
            wait_gnt(0, g, t);
`ifdef CORDIC_ARB_PRIO_EN
            e = 4'b0001;
`else
            e = (n % 2 == 1) ? 4'b0100 : 4'b0001;
`endif
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL prio_gnt%0d: got %b want %b", n, g, e);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_lat1();
        logic [3:0] g;
        int ta, tv, tb;
        reset_pulse();
        iv   = 16'h4321;
        qv   = 16'hA5F7;
        req1 = 4'b0010;
        wait_gnt(1, g, ta);
        total++;
        if (g !== 4'b0010) begin
            bad++;
            $display("FAIL lat1_gnt: got %b want 0010", g);
        end
        wait_valid(1, tv);
        total++;
        if (tv < 0 || tv - ta != 2) begin
            bad++;
            $display("FAIL lat1_latency: got %0d want 2", tv - ta);
        end
        total++;
        if (ch1 !== 2'd1 || ang1 !== cmodel(4'h2, 4'hF)) begin
            bad++;
            $display("FAIL lat1_result: ch=%0d angle=%h want ch=1 angle=%h", ch1, ang1, cmodel(4'h2, 4'hF));
        end
        wait_gnt(1, g, tb);
        req1 = 4'b0000;
        total++;
        if (tb < 0 || tb - ta != 4) begin
            bad++;
            $display("FAIL lat1_spacing: got %0d want 4", tb - ta);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_mid_reset();
        test_priority();
        test_lat1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
